mac_sequencer: RTL and testbench

//  Initiator for the mac start/ready operand interface. Buffers signed operand pairs in a

---
 rtl/mac_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_mac_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Operand-pair FIFO plus job sequencer driving one mac over its start/ready handshake.
// Each job's result is the accumulator delta, so the mac is never cleared.
module mac_sequencer #(
  parameter int unsigned OPSIZE     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LENW       = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  job_start,
  input  logic [LENW-1:0]       job_len,
  output logic                  job_busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPSIZE-1:0]     in_a,
  input  logic [OPSIZE-1:0]     in_b,
  output logic                  mac_start,
  output logic [OPSIZE-1:0]     mac_a,
  output logic [OPSIZE-1:0]     mac_b,
  input  logic [2*OPSIZE-1:0]   mac_out,
  input  logic                  mac_ready,
  output logic                  res_valid,
  output logic [2*OPSIZE-1:0]   res_data,
  output logic                  err_timeout
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam int unsigned ResW = 2 * OPSIZE;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StFinish
  } state_e;

  // ---------------- operand FIFO ----------------
  logic [OPSIZE-1:0] mem_a_q [FIFO_DEPTH];
  logic [OPSIZE-1:0] mem_b_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              full, empty, push, pop;

  state_e state_q, state_d;

  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  // Full blocks a push even if a pop happens in the same cycle.
  assign push     = in_valid && !full;
  assign pop      = (state_q == StIssue) && !empty;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  // ---------------- job sequencer ----------------
  logic [LENW-1:0]   rem_q, rem_d;
  logic [ResW-1:0]   base_q, base_d;
  logic [ResW-1:0]   res_q, res_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [OPSIZE-1:0] a_q, a_d, b_q, b_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              timed_out;

  assign timed_out = (tmo_q == TmoW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    base_d  = base_q;
    res_d   = res_q;
    busy_d  = busy_q;
    err_d   = err_q;
    start_d = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    tmo_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (job_start) begin
          err_d  = 1'b0;
          busy_d = 1'b1;
          base_d = mac_out;
          if (job_len == '0) begin
            res_d   = '0;
            state_d = StFinish;
          end else begin
            rem_d   = job_len;
            state_d = StArm;
          end
        end
      end
      StArm: begin
        if (mac_ready) begin
          base_d  = mac_out;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!empty) begin
          start_d = 1'b1;
          a_d     = mem_a_q[rd_ptr_q];
          b_d     = mem_b_q[rd_ptr_q];
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (!mac_ready) begin
          state_d = StWaitDone;
        end else if (timed_out) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWaitDone: begin
        if (mac_ready) begin
          rem_d = rem_q - LENW'(1);
          if (rem_q == LENW'(1)) begin
            // mac_out is valid in the cycle ready returns, so the result is taken here.
            res_d   = mac_out - base_q;
            state_d = StFinish;
          end else begin
            state_d = StIssue;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      base_q  <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      base_q  <= base_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tmo_q   <= tmo_d;
    end
  end

  assign job_busy    = busy_q;
  assign mac_start   = start_q;
  assign mac_a       = a_q;
  assign mac_b       = b_q;
  assign res_valid   = (state_q == StFinish);
  assign res_data    = res_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural mac, queue-based reference model checked every cycle,
// plus directed cases with hand-computed results.
module tb_mac_sequencer;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_start;
  logic [7:0]  job_len;
  logic        job_busy;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic        mac_start;
  logic [7:0]  mac_a, mac_b;
  logic [15:0] mac_out = 16'h0000;
  logic        mac_ready = 1'b1;
  logic        res_valid;
  logic [15:0] res_data;
  logic        err_timeout;

  mac_sequencer #(
    .OPSIZE    (8),
    .FIFO_DEPTH(DEPTH),
    .LENW      (8),
    .TIMEOUT   (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .job_start  (job_start),
    .job_len    (job_len),
    .job_busy   (job_busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mac_start  (mac_start),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_out    (mac_out),
    .mac_ready  (mac_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] prod16(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[15:0];
  endfunction

  // Behavioural mac: busy for mac_lat cycles (0 = random 1..3); stub mode never leaves idle.
  logic        mac_stub = 1'b0;
  int          mac_lat = 2;
  int          mac_cnt = 0;
  logic [15:0] mac_prod = 16'h0000;

  always @(posedge clk) begin
    if (mac_cnt != 0) begin
      if (mac_cnt == 1) begin
        mac_out   <= mac_out + mac_prod;
        mac_ready <= 1'b1;
      end
      mac_cnt <= mac_cnt - 1;
    end else if (mac_start && mac_ready && !mac_stub) begin
      mac_prod  <= prod16(mac_a, mac_b);
      mac_ready <= 1'b0;
      mac_cnt   <= (mac_lat == 0) ? int'($urandom_range(1, 3)) : mac_lat;
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model state
  pair_t       mq[$];
  logic        m_busy = 1'b0;
  logic [15:0] m_sum = 16'h0000;
  int          m_starts = 0;
  int          m_len = 0;
  logic        prev_err = 1'b0;
  int          res_cnt = 0;
  int          mstarts = 0;
  logic [15:0] last_res = 16'h0000;

  task automatic monitor();
    pair_t p;
    logic  fin;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        m_busy   = 1'b0;
        m_sum    = '0;
        m_starts = 0;
        prev_err = 1'b0;
        continue;
      end
      if (err_timeout && !prev_err) begin
        m_busy   = 1'b0;
        m_sum    = '0;
        m_starts = 0;
      end
      prev_err = err_timeout;
      if (mac_start) begin
        mstarts++;
        chk("start_in_job", 32'(m_busy), 1);
        chk("pop_nonempty", 32'(mq.size() != 0), 1);
        if (mq.size() != 0) begin
          p = mq.pop_front();
          chk("mac_a", 32'(mac_a), 32'(p.a));
          chk("mac_b", 32'(mac_b), 32'(p.b));
          m_sum = m_sum + prod16(p.a, p.b);
          m_starts++;
        end
      end
      chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("job_busy", 32'(job_busy), 32'(m_busy));
      fin = res_valid;
      if (res_valid) begin
        chk("res_in_job", 32'(m_busy), 1);
        chk("res_data", 32'(res_data), 32'(m_sum));
        chk("res_starts", 32'(m_starts), 32'(m_len));
        last_res = res_data;
        res_cnt++;
        m_busy   = 1'b0;
        m_sum    = '0;
        m_starts = 0;
      end
      // Inputs are stable until after the next rising edge: record what it will accept.
      if (in_valid && in_ready) mq.push_back('{a: in_a, b: in_b});
      if (job_start && !m_busy && !fin) begin
        m_busy   = 1'b1;
        m_len    = int'(job_len);
        m_sum    = '0;
        m_starts = 0;
      end
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    logic rdy;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    in_valid = 1'b0;
    if (!done) chk("push_bound", 0, 1);
  endtask

  task automatic start_job(input int len);
    job_start = 1'b1;
    job_len   = 8'(len);
    @(posedge clk);
    #1;
    job_start = 1'b0;
  endtask

  task automatic wait_res(input int c);
    int i;
    for (i = 0; i < 2000 && res_cnt <= c; i++) begin
      @(posedge clk);
      #1;
    end
    if (res_cnt <= c) chk("res_bound", 0, 1);
  endtask

  initial begin
    int c, s, n, len;
    rst_n     = 1'b0;
    job_start = 1'b0;
    job_len   = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_job_busy", 32'(job_busy), 0);
    chk("rst_mac_start", 32'(mac_start), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pair
    push(8'd48, 8'd110);
    c = res_cnt; s = mstarts;
    start_job(1);
    wait_res(c);
    chk("t1_res", 32'(last_res), 32'h14A0);
    chk("t1_starts", 32'(mstarts - s), 1);

    // Two pairs on a nonzero accumulator base
    push(8'hFF, 8'hFF);
    push(8'd127, 8'd127);
    c = res_cnt; s = mstarts;
    start_job(2);
    wait_res(c);
    chk("t2_res", 32'(last_res), 32'h3F02);
    chk("t2_starts", 32'(mstarts - s), 2);

    // FIFO fill: fifth pair held until the job pops
    push(8'd1, 8'd2);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    push(8'd7, 8'd8);
    @(negedge clk);
    chk("t3_full", 32'(in_ready), 0);
    c = res_cnt;
    fork
      push(8'd9, 8'd10);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("t3_held", 32'({in_valid, in_ready}), 32'b10);
        start_job(5);
      end
    join
    wait_res(c);
    chk("t3_res", 32'(last_res), 32'h00BE);

    // Zero-length job
    s = mstarts;
    start_job(0);
    @(negedge clk);
    chk("t4_rv", 32'(res_valid), 1);
    chk("t4_res", 32'(res_data), 0);
    @(negedge clk);
    chk("t4_rv_pulse", 32'(res_valid), 0);
    chk("t4_starts", 32'(mstarts - s), 0);
    @(posedge clk);
    #1;

    // Timeout with a mac that never goes busy
    mac_stub = 1'b1;
    push(8'd2, 8'd3);
    c = res_cnt;
    start_job(1);
    n = 0;
    for (int i = 0; i < 50 && !mac_start; i++) @(negedge clk);
    chk("t5_started", 32'(mac_start), 1);
    for (int i = 0; i < 200 && !err_timeout; i++) begin
      @(negedge clk);
      n++;
    end
    chk("t5_cycles", 32'(n), 64);
    chk("t5_err", 32'(err_timeout), 1);
    chk("t5_busy", 32'(job_busy), 0);
    chk("t5_no_res", 32'(res_cnt), 32'(c));
    mac_stub = 1'b0;
    @(posedge clk);
    #1;

    // Reset during WAIT_DONE
    mac_lat = 10;
    push(8'd1, 8'd1);
    push(8'd2, 8'd2);
    push(8'd3, 8'd3);
    start_job(2);
    for (int i = 0; i < 50 && mac_ready; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("t6_err_cleared", 32'(err_timeout), 0);
    chk("t6_busy", 32'(job_busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_in_ready", 32'(in_ready), 1);
    chk("t6_job_busy", 32'(job_busy), 0);
    chk("t6_res_valid", 32'(res_valid), 0);
    chk("t6_mac_start", 32'(mac_start), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 50 && !mac_ready; i++) begin
      @(posedge clk);
      #1;
    end
    mac_lat = 0;
    push(8'd3, 8'hFC);
    c = res_cnt;
    start_job(1);
    wait_res(c);
    chk("t6_flushed", 32'(last_res), 32'hFFF4);

    // Randomized jobs, checked by the model every cycle
    for (int j = 0; j < 25; j++) begin
      len = int'($urandom_range(0, 7));
      c = res_cnt;
      fork
        begin
          for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            push(8'($urandom), 8'($urandom));
          end
        end
        begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          start_job(len);
        end
      join
      wait_res(c);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
